// File: rtl/cgra_conf_sequencer_pkg.sv
// Shared definitions for the CGRA configuration bus: word layout, CONF type codes
// (also decoded by the PE configuration readers) and the sequencer FSM encoding.
package cgra_conf_sequencer_pkg;

    localparam int CONF_W        = 64;
    localparam int TYPE_LSB      = 0;
    localparam int TYPE_W        = 8;
    localparam int PE_ID_LSB     = 8;
    localparam int PE_ID_W       = 16;
    localparam int PAYLOAD_LSB   = 24;
    localparam int PAYLOAD_W     = 40;

    localparam logic [TYPE_W-1:0] NOT_CONF            = 8'd0;
    localparam logic [TYPE_W-1:0] SET_PE_INSTRUCTION  = 8'd1;
    localparam logic [TYPE_W-1:0] SET_PE_CONST        = 8'd2;
    localparam logic [TYPE_W-1:0] SET_PE_PC_MAX       = 8'd3;
    localparam logic [TYPE_W-1:0] SET_PE_PC_LOOP      = 8'd4;
    localparam logic [TYPE_W-1:0] SET_PE_STORE_IGNORE = 8'd5;
    localparam logic [TYPE_W-1:0] SET_PE_QTD_LOW      = 8'd6;
    localparam logic [TYPE_W-1:0] SET_PE_QTD_HIGH     = 8'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } conf_state_t;

    function automatic logic [TYPE_W-1:0] conf_type(input logic [CONF_W-1:0] word);
        return word[TYPE_LSB +: TYPE_W];
    endfunction

    function automatic logic [PE_ID_W-1:0] conf_pe_id(input logic [CONF_W-1:0] word);
        return word[PE_ID_LSB +: PE_ID_W];
    endfunction

    function automatic logic [PAYLOAD_W-1:0] conf_payload(input logic [CONF_W-1:0] word);
        return word[PAYLOAD_LSB +: PAYLOAD_W];
    endfunction

endpackage

// File: rtl/cgra_conf_sequencer_if.sv
// Host-side signal bundle of the configuration sequencer: session control,
// the word handshake and the status/bus outputs.
interface cgra_conf_sequencer_if
    import cgra_conf_sequencer_pkg::*;
#(
    parameter int QTD_WIDTH = 32
);

    logic                 start;
    logic [QTD_WIDTH-1:0] conf_qtd;

    // Handshake: a word moves in every cycle where conf_valid and conf_ready are both
    // high at the clock edge; conf_valid must not depend on conf_ready, and an offered
    // word may be withdrawn while conf_ready is low.
    logic [CONF_W-1:0]    conf_data;
    logic                 conf_valid;
    logic                 conf_ready;

    logic [CONF_W-1:0]    conf_bus_out;
    logic                 busy;
    logic                 done;
    logic [QTD_WIDTH-1:0] conf_count;
    logic                 bad_type;

    modport master (
        output start, conf_qtd, conf_data, conf_valid,
        input  conf_ready, conf_bus_out, busy, done, conf_count, bad_type
    );

    modport slave (
        input  start, conf_qtd, conf_data, conf_valid,
        output conf_ready, conf_bus_out, busy, done, conf_count, bad_type
    );

endinterface

// File: rtl/cgra_conf_sequencer.sv
// Streams a fixed-length session of configuration words onto the shared PE
// configuration bus, one word per cycle with zero idles, then drains and flags done.
module cgra_conf_sequencer
    import cgra_conf_sequencer_pkg::*;
#(
    parameter int QTD_WIDTH    = 32,
    // Must cover the PE reader bus-to-write-enable latency plus one (>= 3).
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    cgra_conf_sequencer_if.slave     conf,
    output conf_state_t              state_dbg
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    conf_state_t          state_q;
    conf_state_t          state_d;

    logic [QTD_WIDTH-1:0] remaining_q;
    logic [QTD_WIDTH-1:0] count_q;
    logic [DRAIN_W-1:0]   drain_q;
    logic [CONF_W-1:0]    bus_q;
    logic                 done_q;
    logic                 bad_q;

    logic                 ready;
    logic                 start_acc;
    logic                 xfer;
    logic                 drain_last;
    logic                 word_bad;

    always_comb begin
        state_d    = state_q;
        ready      = 1'b0;
        start_acc  = 1'b0;
        xfer       = 1'b0;
        drain_last = 1'b0;
        word_bad   = conf_type(conf.conf_data) > SET_PE_QTD_HIGH;
        case (state_q)
            IDLE: begin
                if (conf.start) begin
                    start_acc = 1'b1;
                    state_d   = (conf.conf_qtd != '0) ? SEND : DRAIN;
                end
            end
            SEND: begin
                ready = 1'b1;
                xfer  = conf.conf_valid;
                if (conf.conf_valid && remaining_q == QTD_WIDTH'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(1)) begin
                    drain_last = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            drain_q     <= '0;
            bus_q       <= '0;
            done_q      <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            // A word occupies the bus for exactly one cycle; every other cycle is NOT_CONF.
            bus_q   <= xfer ? conf.conf_data : '0;
            if (start_acc) begin
                remaining_q <= conf.conf_qtd;
                count_q     <= '0;
                done_q      <= 1'b0;
                bad_q       <= 1'b0;
                drain_q     <= DRAIN_W'(DRAIN_CYCLES);
            end
            if (xfer) begin
                remaining_q <= remaining_q - QTD_WIDTH'(1);
                count_q     <= count_q + QTD_WIDTH'(1);
                if (word_bad) begin
                    bad_q <= 1'b1;
                end
            end
            if (state_q == DRAIN) begin
                drain_q <= drain_q - DRAIN_W'(1);
            end
            if (drain_last) begin
                done_q <= 1'b1;
            end
        end
    end

    assign conf.conf_ready   = ready;
    assign conf.conf_bus_out = bus_q;
    assign conf.busy         = (state_q != IDLE);
    assign conf.done         = done_q;
    assign conf.conf_count   = count_q;
    assign conf.bad_type     = bad_q;
    assign state_dbg         = state_q;

endmodule
